// File: rtl/cfar_seq_pkg.sv
// Shared types and default constants for the CFAR frame sequencer.
package cfar_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT,
    HOLD
  } seq_state_e;

  localparam int SEQ_DATA_W    = 29;
  localparam int SEQ_IDX_W     = 9;
  localparam int SEQ_FRAME_LEN = 512;
  localparam int SEQ_FRM_CNT_W = 16;

  // Result record at the default widths, for integration code and models.
  typedef struct packed {
    logic [SEQ_DATA_W-1:0]    value;
    logic [SEQ_IDX_W-1:0]     index;
    logic [SEQ_FRM_CNT_W-1:0] frame;
    logic                     timeout;
  } seq_result_t;

endpackage

// File: rtl/cfar_seq_result_reg.sv
// Result capture register with a valid/ready hold towards the consumer.
module cfar_seq_result_reg #(
  parameter int DATA_W    = 29,
  parameter int IDX_W     = 9,
  parameter int FRM_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 capture,
  input  logic [DATA_W-1:0]    cap_value,
  input  logic [IDX_W-1:0]     cap_index,
  input  logic [FRM_CNT_W-1:0] cap_frame,
  input  logic                 cap_timeout,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_value,
  output logic [IDX_W-1:0]     res_index,
  output logic [FRM_CNT_W-1:0] res_frame,
  output logic                 res_timeout,
  output logic                 res_valid
);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_value   <= '0;
      res_index   <= '0;
      res_frame   <= '0;
      res_timeout <= 1'b0;
      res_valid   <= 1'b0;
    end else if (capture) begin
      res_value   <= cap_value;
      res_index   <= cap_index;
      res_frame   <= cap_frame;
      res_timeout <= cap_timeout;
      res_valid   <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cfar_frame_sequencer.sv
// Frame sequencer for the CFAR max detector: streams FRAME_LEN samples, then
// waits for and holds the detector result. Optional watchdog: CFAR_SEQ_TIMEOUT_EN.
module cfar_frame_sequencer
  import cfar_seq_pkg::*;
#(
  parameter int DATA_W      = SEQ_DATA_W,
  parameter int IDX_W       = SEQ_IDX_W,
  parameter int FRAME_LEN   = SEQ_FRAME_LEN,
  parameter int FRM_CNT_W   = SEQ_FRM_CNT_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [DATA_W-1:0]    s_power,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DATA_W-1:0]    power_in,
  output logic                 input_valid,
  output logic                 frame_start,
  input  logic [DATA_W-1:0]    max_value,
  input  logic [IDX_W-1:0]     index_out,
  input  logic                 max_valid,
  output logic [DATA_W-1:0]    res_value,
  output logic [IDX_W-1:0]     res_index,
  output logic [FRM_CNT_W-1:0] res_frame,
  output logic                 res_timeout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 err_spurious,
  output logic                 busy
);

  if (FRAME_LEN < 2 || FRAME_LEN > 2**IDX_W || TIMEOUT_CYC < 1) begin : g_param_check
    $error("cfar_frame_sequencer: FRAME_LEN or TIMEOUT_CYC out of range");
  end

  seq_state_e           state_q, state_d;
  logic [IDX_W-1:0]     bin_cnt_q;
  logic [FRM_CNT_W-1:0] frame_cnt_q;
  logic                 accept, last_accept, capture, timeout, res_ack;
  logic [DATA_W-1:0]    cap_value;
  logic [IDX_W-1:0]     cap_index;

  assign s_ready     = (state_q == STREAM);
  assign busy        = (state_q != IDLE);
  assign accept      = s_valid && s_ready;
  assign last_accept = accept && (bin_cnt_q == IDX_W'(FRAME_LEN - 1));
  assign res_ack     = (state_q == HOLD) && res_ready;

`ifdef CFAR_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt_q;

  // A real result on the expiry cycle wins over the abort.
  assign timeout = (state_q == WAIT) && !max_valid &&
                   (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || state_q != WAIT) wait_cnt_q <= '0;
    else                             wait_cnt_q <= wait_cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign capture   = (state_q == WAIT) && (max_valid || timeout);
  assign cap_value = max_valid ? max_value : '0;
  assign cap_index = max_valid ? index_out : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable)      state_d = STREAM;
      STREAM:  if (last_accept) state_d = WAIT;
      WAIT:    if (capture)     state_d = HOLD;
      HOLD:    if (res_ready)   state_d = enable ? STREAM : IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      power_in     <= '0;
      input_valid  <= 1'b0;
      frame_start  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      input_valid <= accept;
      frame_start <= accept && (bin_cnt_q == '0);
      if (accept) begin
        power_in  <= s_power;
        bin_cnt_q <= last_accept ? '0 : bin_cnt_q + 1'b1;
      end
      if (res_ack) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (max_valid && state_q != WAIT) err_spurious <= 1'b1;
    end
  end

  cfar_seq_result_reg #(
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .FRM_CNT_W(FRM_CNT_W)
  ) u_result (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture    (capture),
    .cap_value  (cap_value),
    .cap_index  (cap_index),
    .cap_frame  (frame_cnt_q),
    .cap_timeout(timeout),
    .res_ready  (res_ready),
    .res_value  (res_value),
    .res_index  (res_index),
    .res_frame  (res_frame),
    .res_timeout(res_timeout),
    .res_valid  (res_valid)
  );

endmodule
